adc_capture_pp: RTL and testbench

Parametrised multi-channel serial-ADC capture engine with a ping-pong sample buffer. It is the next generation of the single-channel ADC buffer block. N_CH ADCs share one SCLK/nCS and each drives its own data line. On every nDRDY falling edge one SAMPLE_W-bit word per channel is shifted in and written to one half of an internal buffer, while the host reads completed halves through a registered read port.

---
 rtl/adc_capture_pp.sv | 175 +++++++++++++++++
 tb/tb_adc_capture_pp.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_pp.sv
// Multi-channel serial-ADC capture engine: N_CH SPI lanes share SCLK/nCS and
// fill one half of a ping-pong sample buffer while the host reads the other.
module adc_capture_pp #(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 64,
  parameter int AW       = 1 + $clog2(DEPTH) + $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                nres,
  input  logic                start_pulse,
  input  logic                stop_pulse,
  input  logic                cont,
  input  logic [2:0]          rate,
  input  logic                nDRDY,
  input  logic [N_CH-1:0]     SDIN,
  output logic                SCLK,
  output logic                nCS,
  input  logic [AW-1:0]       read_addr,
  output logic [SAMPLE_W-1:0] dout,
  output logic                write_done,
  output logic                toggle_buff,
  output logic                busy,
  output logic                overrun
);
  localparam int CW = $clog2(N_CH);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(2*SAMPLE_W + 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(2*SAMPLE_W);
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH-1);
  localparam logic [CW-1:0] CH_LAST  = CW'(N_CH-1);

  typedef enum logic [1:0] {IDLE, ARMED, XFER, WRITE} state_t;

  state_t                          state;
  logic [2:0]                      drdy_sync;
  logic                            drdy_evt;
  logic [2:0]                      hcnt, h_max;
  logic [PW-1:0]                   ph;
  logic [CW-1:0]                   wch;
  logic [IW-1:0]                   sample_idx;
  logic                            wr_half, stop_req, shift_en;
  logic [AW-1:0]                   wr_addr;
  logic [N_CH-1:0][SAMPLE_W-1:0]   shreg;
  logic [SAMPLE_W-1:0]             mem [2*N_CH*DEPTH];

  // [1:0] are the synchroniser flops, [2] holds the previous level; reset
  // high so a low nDRDY at reset release is not mistaken for an edge.
  always_ff @(posedge clk or negedge nres)
    if (!nres) drdy_sync <= 3'b111;
    else       drdy_sync <= {drdy_sync[1:0], nDRDY};

  assign drdy_evt = drdy_sync[2] & ~drdy_sync[1];

  // Shift on the edge that drives SCLK high: end of an even (low) phase.
  assign shift_en = (state == XFER) && (hcnt == h_max) && !ph[0] && (ph != PH_LAST);

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    adc_capture_pp_lane #(.SAMPLE_W(SAMPLE_W)) u_lane (
      .clk      (clk),
      .nres     (nres),
      .shift_en (shift_en),
      .sdin     (SDIN[g]),
      .q        (shreg[g])
    );
  end

  assign wr_addr = {wr_half, sample_idx, wch};

  always_ff @(posedge clk)
    if (state == WRITE) mem[wr_addr] <= shreg[wch];

  // Non-blocking read of the old word gives read-first on a collision.
  always_ff @(posedge clk or negedge nres)
    if (!nres) dout <= '0;
    else       dout <= mem[read_addr];

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state       <= IDLE;
      SCLK        <= 1'b0;
      nCS         <= 1'b1;
      write_done  <= 1'b0;
      toggle_buff <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      hcnt        <= '0;
      h_max       <= '0;
      ph          <= '0;
      wch         <= '0;
      sample_idx  <= '0;
      wr_half     <= 1'b0;
      stop_req    <= 1'b0;
    end else begin
      write_done <= 1'b0;
      case (state)
        IDLE: if (start_pulse) begin
          state      <= ARMED;
          busy       <= 1'b1;
          sample_idx <= '0;
          wr_half    <= 1'b0;
          overrun    <= 1'b0;
          stop_req   <= 1'b0;
        end
        ARMED: begin
          if (stop_pulse) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (drdy_evt) begin
            state <= XFER;
            nCS   <= 1'b0;
            SCLK  <= 1'b0;
            hcnt  <= '0;
            ph    <= '0;
            h_max <= rate;
          end
        end
        XFER: begin
          if (drdy_evt)   overrun  <= 1'b1;
          if (stop_pulse) stop_req <= 1'b1;
          if (hcnt == h_max) begin
            hcnt <= '0;
            if (ph == PH_LAST) begin
              nCS   <= 1'b1;
              SCLK  <= 1'b0;
              wch   <= '0;
              state <= WRITE;
            end else begin
              ph   <= ph + 1'b1;
              SCLK <= ~ph[0];
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        WRITE: begin
          if (drdy_evt)   overrun  <= 1'b1;
          if (stop_pulse) stop_req <= 1'b1;
          if (wch == CH_LAST) begin
            sample_idx <= sample_idx + 1'b1;
            if (sample_idx == IDX_LAST) begin
              write_done  <= 1'b1;
              toggle_buff <= wr_half;
              wr_half     <= ~wr_half;
            end
            if (stop_req || stop_pulse || (sample_idx == IDX_LAST && !cont)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ARMED;
            end
          end else begin
            wch <= wch + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// Per-channel MSB-first deserialiser.
module adc_capture_pp_lane #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                nres,
  input  logic                shift_en,
  input  logic                sdin,
  output logic [SAMPLE_W-1:0] q
);
  always_ff @(posedge clk or negedge nres)
    if (!nres)         q <= '0;
    else if (shift_en) q <= {q[SAMPLE_W-2:0], sdin};
endmodule

// File: tb/tb_adc_capture_pp.sv
// Bench for adc_capture_pp: SPI framing table, single-shot, randomized
// continuous ping-pong against a buffer model, overrun and mid-transfer reset.
`timescale 1ns/1ps
module tb_adc_capture_pp;
  localparam int N_CH = 2, SW = 16, DEPTH = 64;
  localparam int AW = 1 + $clog2(DEPTH) + $clog2(N_CH);

  logic clk = 1'b0, nres = 1'b0, start_pulse = 1'b0, stop_pulse = 1'b0, cont = 1'b0, nDRDY = 1'b1;
  logic [2:0] rate = 3'd0;
  logic [N_CH-1:0] SDIN;
  logic SCLK, nCS;
  logic [AW-1:0] read_addr = '0;
  logic [SW-1:0] dout;
  logic write_done, toggle_buff, busy, overrun;

  int n_pass = 0, n_tot = 0;
  int wd_cnt = 0;
  logic wd_tog = 1'b0;

  always #20 clk = ~clk;

  adc_capture_pp #(.N_CH(N_CH), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nres(nres), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .cont(cont), .rate(rate), .nDRDY(nDRDY), .SDIN(SDIN), .SCLK(SCLK), .nCS(nCS),
    .read_addr(read_addr), .dout(dout), .write_done(write_done),
    .toggle_buff(toggle_buff), .busy(busy), .overrun(overrun)
  );

  // ADC model, SPI mode 0: word latched at nCS fall, shifted on SCLK fall.
  logic [N_CH-1:0][SW-1:0] adc_word = '0, adc_sh = '0;
  logic ncs_q = 1'b1, sclk_q = 1'b0;
  always @(nCS or SCLK) begin
    if (ncs_q === 1'b1 && nCS === 1'b0) adc_sh = adc_word;
    else if (nCS === 1'b0 && sclk_q === 1'b1 && SCLK === 1'b0)
      for (int c = 0; c < N_CH; c++) adc_sh[c] = adc_sh[c] << 1;
    ncs_q = nCS;
    sclk_q = SCLK;
  end
  always_comb begin
    SDIN = '0;
    for (int c = 0; c < N_CH; c++) SDIN[c] = adc_sh[c][SW-1];
  end

  always @(negedge clk)
    if (nres && write_done) begin
      wd_cnt++;
      wd_tog = toggle_buff;
    end

  initial begin
    #3_600_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_pulse = 1'b1; tick(1); start_pulse = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_pulse = 1'b1; tick(1); stop_pulse = 1'b0;
  endtask

  task automatic drdy(input int period);
    nDRDY = 1'b0; tick(4); nDRDY = 1'b1; tick(period - 4);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy && k < 2000) begin tick(1); k++; end
    chk(nm, busy, 0);
  endtask

  function automatic logic [AW-1:0] addr(input int h, input int i, input int c);
    return AW'((h * DEPTH + i) * N_CH + c);
  endfunction

  task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [SW-1:0] exp);
    read_addr = a; tick(1);
    chk(nm, dout, exp);
  endtask

  function automatic logic [SW-1:0] inv(input int k);
    logic [SW-1:0] w;
    w = SW'(k);
    return ~w;
  endfunction

  typedef struct { logic [2:0] rate; int lat; int low; int rises; } frm_t;
  frm_t ftab[4];
  logic [SW-1:0] exp_mem [2*N_CH*DEPTH];
  int lat, low, rises, base, k, r, svc, step;
  logic prev;

  initial begin
    ftab[0] = '{3'd0, 3,  33, 16};
    ftab[1] = '{3'd3, 3, 132, 16};
    ftab[2] = '{3'd1, 3,  66, 16};
    ftab[3] = '{3'd7, 3, 264, 16};

    // Reset held with nDRDY toggling
    for (int i = 0; i < 6; i++) begin nDRDY = i[0]; tick(1); end
    chk("rst_sclk", SCLK, 0);
    chk("rst_ncs", nCS, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write_done", write_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_dout", dout, 0);
    chk("rst_toggle", toggle_buff, 0);
    nDRDY = 1'b1; tick(2); nres = 1'b1; tick(3);

    // nDRDY in IDLE is ignored
    drdy(20);
    chk("idle_drdy_ncs", nCS, 1);
    chk("idle_drdy_busy", busy, 0);

    // SPI framing table
    for (int t = 0; t < 4; t++) begin
      rate = ftab[t].rate; cont = 1'b0;
      pulse_start();
      chk("start_busy", busy, 1);
      nDRDY = 1'b0; lat = 0;
      while (nCS && lat < 20) begin tick(1); lat++; end
      nDRDY = 1'b1;
      chk("frm_latency", lat, ftab[t].lat);
      chk("frm_sclk_at_ncs_fall", SCLK, 0);
      low = 0; rises = 0; prev = SCLK;
      while (!nCS && low < 1000) begin
        tick(1); low++;
        if (SCLK && !prev) rises++;
        prev = SCLK;
      end
      chk("frm_ncs_low", low, ftab[t].low);
      chk("frm_sclk_rises", rises, ftab[t].rises);
      chk("frm_sclk_at_ncs_rise", SCLK, 0);
      tick(3); pulse_stop();
      chk("frm_stop_busy", busy, 0);
    end

    // Single-shot: ch0 = k, ch1 = ~k
    rate = 3'd1; cont = 1'b0; pulse_start(); base = wd_cnt;
    for (int n = 0; n < DEPTH; n++) begin
      adc_word[0] = SW'(n); adc_word[1] = inv(n);
      drdy(100);
      if (n == DEPTH - 2) chk("ss_no_wd_early", wd_cnt - base, 0);
    end
    chk("ss_wd_count", wd_cnt - base, 1);
    chk("ss_wd_toggle", wd_tog, 0);
    chk("ss_toggle", toggle_buff, 0);
    chk("ss_busy", busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_chk("ss_rd_ch0", addr(0, i, 0), SW'(i));
      rd_chk("ss_rd_ch1", addr(0, i, 1), inv(i));
    end

    // Continuous, random data and rate; mid-run start must be ignored
    rate = 3'($urandom_range(0, 1)); cont = 1'b1; pulse_start(); base = wd_cnt;
    for (int n = 0; n < 130; n++) begin
      for (int c = 0; c < N_CH; c++) begin
        adc_word[c] = SW'($urandom);
        exp_mem[addr((n / DEPTH) % 2, n % DEPTH, c)] = adc_word[c];
      end
      if (n == 10) pulse_start();
      drdy(100);
      if (n == 63)  begin chk("cont_wd1", wd_cnt - base, 1); chk("cont_tog1", wd_tog, 0); end
      if (n == 127) begin chk("cont_wd2", wd_cnt - base, 2); chk("cont_tog2", wd_tog, 1); end
    end
    chk("cont_busy_running", busy, 1);
    pulse_stop();
    wait_idle("cont_stop_idle");
    chk("cont_wd_final", wd_cnt - base, 2);
    for (int a = 0; a < 2 * N_CH * DEPTH; a++) rd_chk("cont_rd", AW'(a), exp_mem[a]);

    // Overrun: period 20 cycles, shorter than the service time
    rate = 3'd1; cont = 1'b0; pulse_start();
    chk("ovr_clear_start", overrun, 0);
    for (int n = 0; n < 32; n++) begin
      adc_word[0] = SW'(n); adc_word[1] = inv(n);
      drdy(20);
    end
    tick(100); pulse_stop(); wait_idle("ovr_idle");
    chk("ovr_set", overrun, 1);
    svc  = 3 + (2 * SW + 1) * 2 + N_CH + 1;
    step = (svc + 19) / 20;
    for (int i = 0; i < 8; i++) begin
      rd_chk("ovr_rd_ch0", addr(0, i, 0), SW'(i * step));
      rd_chk("ovr_rd_ch1", addr(0, i, 1), inv(i * step));
    end
    pulse_start();
    chk("ovr_cleared", overrun, 0);
    pulse_stop();

    // Reset after 10 SCLK rising edges
    rate = 3'd1; cont = 1'b0; pulse_start();
    adc_word[0] = 16'h1234; adc_word[1] = 16'h4321;
    nDRDY = 1'b0; r = 0; k = 0; prev = 1'b0;
    while (r < 10 && k < 500) begin
      tick(1); k++;
      if (SCLK && !prev) r++;
      prev = SCLK;
    end
    chk("mid_rises_reached", r, 10);
    #5 nres = 1'b0;
    #1;
    chk("mid_rst_ncs", nCS, 1);
    chk("mid_rst_sclk", SCLK, 0);
    chk("mid_rst_busy", busy, 0);
    nDRDY = 1'b1; tick(2); nres = 1'b1; tick(2);
    pulse_start();
    adc_word[0] = 16'hA5C3; adc_word[1] = 16'h3C5A;
    drdy(100); pulse_stop(); wait_idle("mid_idle");
    rd_chk("mid_rd_ch0", addr(0, 0, 0), 16'hA5C3);
    rd_chk("mid_rd_ch1", addr(0, 0, 1), 16'h3C5A);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
